// File: rtl/layer_engine.sv
// layer_engine: one dense-layer neuron pass.
// Streams N_INPUTS pixel/weight beats into a signed multiply-accumulate,
// adds a bias, then saturates the sum to OUT_W bits and hands it downstream.
// Optional build macro: LAYER_ENGINE_RELU_EN. When it is defined, negative
// sums are clamped to zero before saturation.
module layer_engine #(
    parameter int N_INPUTS = 784,
    parameter int ACC_W    = 32,
    parameter int OUT_W    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    layer_en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_pixel,
    input  logic signed [7:0]       in_weight,
    input  logic signed [15:0]      bias,
    output logic [9:0]              in_idx,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    layer_done,
    output logic                    busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_BIAS = 3'd2,
        S_OUT  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [9:0] LAST_IDX = 10'(N_INPUTS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Clamp a full-width sum into the signed OUT_W range.
    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
        logic signed [OUT_W-1:0] r;
        if (v > SAT_MAX) begin
            r = SAT_MAX[OUT_W-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[OUT_W-1:0];
        end else begin
            r = v[OUT_W-1:0];
        end
        return r;
    endfunction

    state_t                  state_r;
    state_t                  state_s;
    logic                    en_prev_r;
    logic                    armed_r;
    logic signed [ACC_W-1:0] acc_r;
    logic [9:0]              idx_r;
    logic signed [OUT_W-1:0] out_data_r;

    logic                    start_s;
    logic                    xfer_s;
    logic signed [16:0]      prod_s;
    logic signed [ACC_W-1:0] prod_ext_s;
    logic signed [ACC_W-1:0] sum_s;
    logic signed [ACC_W-1:0] sum_act_s;

    // armed_r masks the first cycle after reset so a level already high at release is not an edge.
    assign start_s    = layer_en & ~en_prev_r & armed_r;
    assign xfer_s     = in_valid & (state_r == S_RUN);
    assign prod_s     = $signed({1'b0, in_pixel}) * in_weight;
    assign prod_ext_s = {{(ACC_W-17){prod_s[16]}}, prod_s};

    // Bias add and optional rectification ahead of saturation.
    always_comb begin
        sum_s = acc_r + {{(ACC_W-16){bias[15]}}, bias};
`ifdef LAYER_ENGINE_RELU_EN
        if (sum_s[ACC_W-1]) begin
            sum_act_s = {ACC_W{1'b0}};
        end else begin
            sum_act_s = sum_s;
        end
`else
        sum_act_s = sum_s;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; dropping layer_en aborts only while accumulating.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_s) state_s = S_RUN;
                else         state_s = S_IDLE;
            end
            S_RUN: begin
                if (!layer_en)                           state_s = S_IDLE;
                else if (xfer_s && (idx_r == LAST_IDX))  state_s = S_BIAS;
                else                                     state_s = S_RUN;
            end
            S_BIAS: begin
                if (!layer_en) state_s = S_IDLE;
                else           state_s = S_OUT;
            end
            S_OUT: begin
                if (out_ready) state_s = S_DONE;
                else           state_s = S_OUT;
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Datapath: edge detector, accumulator, beat index and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_prev_r  <= 1'b0;
            armed_r    <= 1'b0;
            acc_r      <= {ACC_W{1'b0}};
            idx_r      <= 10'd0;
            out_data_r <= {OUT_W{1'b0}};
        end else begin
            en_prev_r <= layer_en;
            armed_r   <= 1'b1;
            case (state_r)
                S_IDLE: begin
                    if (start_s) begin
                        acc_r <= {ACC_W{1'b0}};
                        idx_r <= 10'd0;
                    end
                end
                S_RUN: begin
                    if (!layer_en) begin
                        acc_r <= {ACC_W{1'b0}};
                        idx_r <= 10'd0;
                    end else if (xfer_s) begin
                        acc_r <= acc_r + prod_ext_s;
                        idx_r <= (idx_r == LAST_IDX) ? 10'd0 : idx_r + 10'd1;
                    end
                end
                S_BIAS: begin
                    acc_r <= {ACC_W{1'b0}};
                    idx_r <= 10'd0;
                    if (layer_en) begin
                        out_data_r <= sat_out(sum_act_s);
                    end
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign in_ready   = (state_r == S_RUN);
    assign out_valid  = (state_r == S_OUT);
    assign layer_done = (state_r == S_DONE);
    assign busy       = (state_r != S_IDLE);
    assign in_idx     = idx_r;
    assign out_data   = out_data_r;

endmodule

// File: tb/tb_layer_engine.sv
// Directed self-checking bench for layer_engine (default parameters).
module tb_layer_engine;

    localparam int N = 784;

    logic               clk = 1'b0;
    logic               reset;
    logic               layer_en;
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         in_pixel;
    logic signed [7:0]  in_weight;
    logic signed [15:0] bias;
    logic [9:0]         in_idx;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;
    logic               layer_done;
    logic               busy;

    int total = 0;
    int bad   = 0;

    layer_engine dut (
        .clk(clk), .reset(reset), .layer_en(layer_en),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pixel(in_pixel), .in_weight(in_weight), .bias(bias),
        .in_idx(in_idx), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .layer_done(layer_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference saturation of the exact sum.
    function automatic logic signed [15:0] ref_sat(input longint s);
        longint t;
        t = s;
`ifdef LAYER_ENGINE_RELU_EN
        if (t < 0) t = 0;
`endif
        if (t > 32767)  return 16'sh7fff;
        if (t < -32768) return 16'sh8000;
        return t[15:0];
    endfunction

    // Raise layer_en and step over the sampling edge.
    task automatic start(output int lat);
        layer_en = 1'b1;
        tick();
        lat = 1;
    endtask

    // Push n beats (constant or random values, optional in_valid gaps).
    task automatic feed(input int n, input bit rnd, input logic [7:0] px,
                        input logic signed [7:0] wt, input bit gaps,
                        inout longint acc_m, inout int lat);
        int cnt;
        logic [7:0] p;
        logic signed [7:0] w;
        cnt = 0;
        while (cnt < n && lat < 20000) begin
            if (rnd) begin
                p = 8'($urandom_range(0, 255));
                w = 8'($urandom_range(0, 255));
            end else begin
                p = px;
                w = wt;
            end
            in_pixel  = p;
            in_weight = w;
            in_valid  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (in_valid && in_ready) begin
                cnt++;
                acc_m += longint'(p) * longint'(w);
            end
            tick();
            lat++;
        end
        in_valid = 1'b0;
    endtask

    // Wait for out_valid, then handshake until layer_done appears.
    task automatic wait_out(input bit bp, input bit drop_en, output logic signed [15:0] got,
                            output bit to, output bit stable, inout int lat);
        to = 1'b0;
        stable = 1'b1;
        while (!out_valid && lat < 20000) begin
            tick();
            lat++;
        end
        if (!out_valid) to = 1'b1;
        got = out_data;
        if (drop_en) layer_en = 1'b0;
        while (!layer_done && lat < 20000) begin
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_data !== got) stable = 1'b0;
            tick();
            lat++;
        end
        if (!layer_done) to = 1'b1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; layer_en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_pixel = 8'd0; in_weight = 8'sd0; bias = 16'sd0;
        repeat (3) tick();
        total++;
        if ({in_ready, out_valid, layer_done, busy} !== 4'b0000 || in_idx !== 10'd0 || out_data !== 16'sd0) begin
            bad++;
            $display("FAIL reset_values: got rdy=%b ov=%b done=%b busy=%b idx=%0d data=%0d, want all 0",
                     in_ready, out_valid, layer_done, busy, in_idx, out_data);
        end
        reset = 1'b0;
        repeat (5) tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_en_high_no_start: busy=%b want 0", busy);
        end
        layer_en = 1'b0;
        tick();
    endtask

    task automatic test_ones();
        longint m; int lat; logic signed [15:0] got; bit to, st;
        m = 0; bias = 16'sd0;
        start(lat);
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || in_idx !== 10'd0) begin
            bad++;
            $display("FAIL start_state: busy=%b rdy=%b idx=%0d want 1 1 0", busy, in_ready, in_idx);
        end
        feed(N, 1'b0, 8'd1, 8'sd1, 1'b0, m, lat);
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL bias_state: rdy=%b busy=%b want 0 1", in_ready, busy);
        end
        wait_out(1'b0, 1'b0, got, to, st, lat);
        total++;
        if (to || got !== 16'sd784) begin
            bad++;
            $display("FAIL ones_result: got %0d timeout=%b want 784", got, to);
        end
        total++;
        if (lat !== N + 3) begin
            bad++;
            $display("FAIL ones_latency: got %0d cycles want %0d", lat, N + 3);
        end
        total++;
        if (layer_done !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse: done=%b ov=%b want 1 0", layer_done, out_valid);
        end
        repeat (4) tick();
        total++;
        if (layer_done !== 1'b0 || busy !== 1'b0 || in_idx !== 10'd0) begin
            bad++;
            $display("FAIL en_held_no_restart: done=%b busy=%b idx=%0d want 0 0 0", layer_done, busy, in_idx);
        end
        layer_en = 1'b0;
        tick();
    endtask

    task automatic test_saturate();
        longint m; int lat; logic signed [15:0] got; bit to, st;
        m = 0; bias = 16'sd0;
        start(lat);
        feed(N, 1'b0, 8'd255, 8'sd127, 1'b0, m, lat);
        wait_out(1'b0, 1'b0, got, to, st, lat);
        total++;
        if (to || got !== 16'sd32767) begin
            bad++;
            $display("FAIL saturate_pos: got %0d timeout=%b want 32767", got, to);
        end
        layer_en = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_negative();
        longint m; int lat; logic signed [15:0] got, want; bit to, st;
        m = 0; bias = 16'sd5;
`ifdef LAYER_ENGINE_RELU_EN
        want = 16'sd0;
`else
        want = -16'sd7835;
`endif
        start(lat);
        feed(N, 1'b0, 8'd10, -8'sd1, 1'b0, m, lat);
        wait_out(1'b0, 1'b1, got, to, st, lat);
        total++;
        if (to || got !== want) begin
            bad++;
            $display("FAIL negative_sum: got %0d timeout=%b want %0d", got, to, want);
        end
        tick();
    endtask

    task automatic test_stall_abort();
        longint m; int lat; logic signed [15:0] got; bit to, st, seen;
        m = 0; bias = 16'sd0;
        start(lat);
        feed(5, 1'b0, 8'd3, 8'sd3, 1'b0, m, lat);
        repeat (20) tick();
        total++;
        if (in_idx !== 10'd5 || busy !== 1'b1) begin
            bad++;
            $display("FAIL stall_hold: idx=%0d busy=%b want 5 1", in_idx, busy);
        end
        feed(95, 1'b0, 8'd3, 8'sd3, 1'b0, m, lat);
        total++;
        if (in_idx !== 10'd100) begin
            bad++;
            $display("FAIL idx_100: idx=%0d want 100", in_idx);
        end
        layer_en = 1'b0;
        tick();
        seen = 1'b0;
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || in_idx !== 10'd0) begin
            bad++;
            $display("FAIL abort_idle: busy=%b rdy=%b idx=%0d want 0 0 0", busy, in_ready, in_idx);
        end
        repeat (10) begin
            if (out_valid || layer_done) seen = 1'b1;
            tick();
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL abort_no_output: out_valid/layer_done seen=%b want 0", seen);
        end
        m = 0;
        start(lat);
        feed(N, 1'b0, 8'd1, 8'sd1, 1'b0, m, lat);
        wait_out(1'b0, 1'b0, got, to, st, lat);
        total++;
        if (to || got !== 16'sd784) begin
            bad++;
            $display("FAIL after_abort_result: got %0d timeout=%b want 784", got, to);
        end
        layer_en = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset_in_out();
        longint m; int lat; int guard;
        m = 0; bias = 16'sd0;
        start(lat);
        feed(N, 1'b0, 8'd2, 8'sd1, 1'b0, m, lat);
        guard = 0;
        while (!out_valid && guard < 20) begin
            tick();
            guard++;
        end
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'sd1568) begin
            bad++;
            $display("FAIL out_before_reset: ov=%b data=%0d want 1 1568", out_valid, out_data);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({in_ready, out_valid, layer_done, busy} !== 4'b0000 || in_idx !== 10'd0 || out_data !== 16'sd0) begin
            bad++;
            $display("FAIL reset_mid_out: rdy=%b ov=%b done=%b busy=%b idx=%0d data=%0d want all 0",
                     in_ready, out_valid, layer_done, busy, in_idx, out_data);
        end
        repeat (6) tick();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_out_no_restart: busy=%b want 0", busy);
        end
        layer_en = 1'b0;
        tick();
    endtask

    task automatic test_random();
        longint m; int lat; logic signed [15:0] got, want; bit to, st;
        for (int r = 0; r < 2; r++) begin
            bias = 16'($urandom_range(0, 65535));
            m = longint'(bias);
            start(lat);
            feed(N, 1'b1, 8'd0, 8'sd0, 1'b1, m, lat);
            wait_out(1'b1, 1'b0, got, to, st, lat);
            want = ref_sat(m);
            total++;
            if (to || got !== want) begin
                bad++;
                $display("FAIL random_result[%0d]: got %0d timeout=%b want %0d", r, got, to, want);
            end
            total++;
            if (!st) begin
                bad++;
                $display("FAIL random_out_stable[%0d]: out_data changed under backpressure", r);
            end
            total++;
            if (in_idx !== 10'd0) begin
                bad++;
                $display("FAIL random_idx_end[%0d]: idx=%0d want 0", r, in_idx);
            end
            layer_en = 1'b0;
            repeat (2) tick();
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_saturate();
        test_negative();
        test_stall_abort();
        test_reset_in_out();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/layer_engine.md
LAYER_ENGINE -- requirements
Module: layer_engine

Interface
REQ-001 Parameter N_INPUTS, default 784, number of input beats per layer pass.
REQ-002 Parameter ACC_W, default 32, signed accumulator width.
REQ-003 Parameter OUT_W, default 16, signed result width.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 layer_en  input  1  enable level driven by the layer controller; a rising edge starts a pass.
REQ-007 in_valid  input  1  pixel/weight beat valid.
REQ-008 in_ready  output  1  engine accepts a beat this cycle.
REQ-009 in_pixel  input  8  unsigned input activation.
REQ-010 in_weight  input  8  signed weight paired with in_pixel.
REQ-011 bias  input  16  signed bias, sampled in BIAS state.
REQ-012 in_idx  output  10  index of the next beat expected (0..N_INPUTS-1).
REQ-013 out_valid  output  1  result valid, held until accepted.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 out_data  output  OUT_W  signed result.
REQ-016 layer_done  output  1  one-cycle pulse when a pass completes.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 States: IDLE, RUN, BIAS, OUT, DONE.
REQ-019 IDLE->RUN on the cycle where layer_en=1 and its registered previous value=0; accumulator and in_idx cleared on that transition.
REQ-020 layer_en held high after a pass does not restart; a new rising edge is required.
REQ-021 in_ready=1 only in RUN; a beat transfers when in_valid&in_ready.
REQ-022 Per transfer: acc <= acc + (zero-extended in_pixel * signed in_weight), full-precision 17-bit signed product, sign-extended to ACC_W; in_idx increments.
REQ-023 Transfer with in_idx=N_INPUTS-1 -> BIAS next cycle; in_ready=0 from that cycle.
REQ-024 BIAS (one cycle): sum <= acc + sign-extended bias; -> OUT.
REQ-025 OUT: out_valid=1, out_data stable; -> DONE on out_valid&out_ready.
REQ-026 DONE (one cycle): layer_done=1; -> IDLE.
REQ-027 Result saturates to OUT_W signed range: sum>32767 -> 32767, sum<-32768 -> -32768 (OUT_W=16).
REQ-028 layer_en=0 in RUN or BIAS aborts: -> IDLE next cycle, accumulator cleared, no out_valid, no layer_done.
REQ-029 layer_en deassertion in OUT or DONE does not abort; result still delivered.
REQ-030 in_valid stalls (in_valid=0) in RUN hold acc and in_idx unchanged indefinitely.
REQ-031 Minimum pass latency: N_INPUTS+3 cycles from start edge to layer_done with no stalls.

Reset
REQ-032 reset=1 at any clock edge forces IDLE regardless of state, including mid-pass.
REQ-033 Reset values: in_ready=0, out_valid=0, out_data=0, layer_done=0, busy=0, in_idx=0, accumulator=0, registered layer_en=0.
REQ-034 layer_en already high when reset releases does not start a pass (no rising edge seen).

Configuration
REQ-035 Macro LAYER_ENGINE_RELU_EN: when defined, negative sums are clamped to 0 before saturation; when undefined, signed result passes through saturation only.

Verification
REQ-036 784 beats pixel=1 weight=1, bias=0 -> out_data=784, layer_done 1 cycle after out handshake.
REQ-037 784 beats pixel=255 weight=127, bias=0 -> out_data=32767 (saturated).
REQ-038 784 beats pixel=10 weight=-1, bias=5 -> out_data=-7835 without RELU_EN, 0 with RELU_EN.
REQ-039 Deassert layer_en after 100 beats -> IDLE, no out_valid, no layer_done; next rising edge yields correct fresh result.
REQ-040 Assert reset during OUT with out_ready=0 -> all outputs at reset values next cycle; layer_en held high -> no restart.
REQ-041 Random in_valid gaps and out_ready backpressure, 784 beats -> result matches reference model, in_idx ends at 0 after pass.
